flagged_port_loader: RTL and testbench
======================================

# flagged_port_loader

Host-side writer for the flagged-port match path. Accepts 32-bit command words from the Atom over a valid/ready handshake, builds a shadow table of up to NUM_PORTS flagged ports, and on COMMIT waits for the packet stream to go idle before atomically swapping the table into the comparators. During the swap it asserts the comparators' clear for FLUSH_CYCLES so no stale partial match survives.

## Interface
- NUM_PORTS, 4: table entries, one per port comparator instance
- PORT_W, 16: flagged port width
- FLUSH_CYCLES, 3: comparator pipeline depth; clear is held this many cycles (≥1)

- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- wr_valid  in  1  host command word valid
- wr_ready  out  1  loader can accept a command
- wr_data  in  32  [31:30] opcode, [29:16] index, [15:0] port value
- frame_active  in  1  high while a packet is in flight on the sniff stream
- flagged_port  out  NUM_PORTS*PORT_W  active table; entry i at [i*PORT_W +: PORT_W]
- port_valid  out  NUM_PORTS  active entry enable mask
- comp_clear  out  1  clear to all port comparators
- wr_err  out  1  one-cycle pulse: rejected command
- commit_done  out  1  one-cycle pulse: swap complete

## Operation
- Opcodes: 00 NOP, 01 WRITE, 10 CLEAR_ALL, 11 COMMIT. Handshake on wr_valid && wr_ready at a rising edge.
- WRITE: index < NUM_PORTS → shadow_port[index] <= wr_data[15:0], shadow_valid[index] <= 1. index ≥ NUM_PORTS → no table change, wr_err pulses the next cycle. Same index twice: last write wins.
- CLEAR_ALL: shadow_valid <= 0; shadow ports unchanged; active table untouched.
- NOP: accepted, no effect.
- COMMIT: FSM IDLE → WAIT_IDLE.
- FSM states:
  - IDLE: wr_ready = 1.
  - WAIT_IDLE: wr_ready = 0. At the first edge that samples frame_active = 0: flagged_port <= shadow_port, port_valid <= shadow_valid, comp_clear <= 1, flush counter <= FLUSH_CYCLES-1, go to FLUSH.
  - FLUSH: wr_ready = 0. Counter decrements each edge. At the edge where the counter is 0: comp_clear <= 0, commit_done <= 1 for one cycle, go to IDLE.
- comp_clear is high for exactly FLUSH_CYCLES consecutive cycles per commit and is never asserted outside FLUSH.
- Shadow edits never reach the outputs without a COMMIT.
- Reset values: flagged_port 0, port_valid 0, comp_clear 0, wr_err 0, commit_done 0, shadow cleared, state IDLE.
- wr_ready is held low while rst is asserted.
- Reset mid-WAIT_IDLE or mid-FLUSH: the commit is abandoned, and comp_clear drops asynchronously.
- frame_active held high indefinitely: the loader stays in WAIT_IDLE; there is no timeout.

## Timing
- Command accepted at edge T: shadow state is visible from T+1; wr_err, if any, is high during the cycle after T.
- COMMIT at edge T with frame_active low from then on:
  - new table and comp_clear = 1 from edge T+1;
  - comp_clear falls and commit_done rises at edge T+1+FLUSH_CYCLES;
  - wr_ready is high again in that same cycle.
- Minimum COMMIT-to-COMMIT spacing: FLUSH_CYCLES+2 cycles.
- All outputs are registered, except wr_ready, which decodes the registered state and is gated by rst.

## Structure
- Package flagged_port_loader_pkg holds:
  - opcode enum (OP_NOP, OP_WRITE, OP_CLEAR_ALL, OP_COMMIT);
  - state enum (IDLE, WAIT_IDLE, FLUSH);
  - field position constants for wr_data.
- Single module, no sub-module. The flush counter is inline and $clog2(FLUSH_CYCLES)+1 bits wide.

## Test plan
- Reset, then WRITE idx0 = 0x0050, WRITE idx2 = 0x01BB, COMMIT with frame_active = 0 → port_valid = 4'b0101, entry0 = 0x0050, entry2 = 0x01BB one cycle after COMMIT; comp_clear high exactly 3 cycles; one commit_done pulse.
- WRITE idx1 = 0x0016 without COMMIT → flagged_port and port_valid unchanged for 20 cycles.
- COMMIT while frame_active = 1 for 10 cycles → wr_ready = 0, outputs unchanged, comp_clear = 0 throughout; swap happens on the edge after frame_active falls.
- WRITE idx 5 with NUM_PORTS = 4 → wr_err single-cycle pulse, shadow unchanged (verify via a subsequent COMMIT).
- CLEAR_ALL then COMMIT → port_valid = 0, entry values retained.
- Assert rst during FLUSH cycle 2 → comp_clear drops immediately; all outputs at reset values; wr_ready = 1 on the first cycle after rst deasserts.

Source files
------------

// File: rtl/flagged_port_loader_pkg.sv
// Shared types and command-word field positions for the flagged-port loader.
package flagged_port_loader_pkg;

    typedef enum logic [1:0] {
        OP_NOP       = 2'b00,
        OP_WRITE     = 2'b01,
        OP_CLEAR_ALL = 2'b10,
        OP_COMMIT    = 2'b11
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_IDLE = 2'd1,
        FLUSH     = 2'd2
    } state_e;

    localparam int DATA_W   = 32;
    localparam int OP_MSB   = 31;
    localparam int OP_LSB   = 30;
    localparam int IDX_MSB  = 29;
    localparam int IDX_LSB  = 16;
    localparam int IDX_W    = IDX_MSB - IDX_LSB + 1;
    localparam int PORT_MSB = 15;
    localparam int PORT_LSB = 0;

endpackage

// File: rtl/flagged_port_loader_if.sv
// Host command channel: 32-bit words over a valid/ready handshake.
interface flagged_port_loader_if;
    import flagged_port_loader_pkg::*;

    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;

    modport master (output wr_valid, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_data, output wr_ready);

endinterface

// File: rtl/flagged_port_loader.sv
// Builds a shadow flagged-port table from host commands and swaps it into the
// comparators on COMMIT once the packet stream is idle, clearing them meanwhile.
//
// state     | meaning
// IDLE      | accepting commands, editing the shadow table
// WAIT_IDLE | COMMIT received, waiting for frame_active to drop
// FLUSH     | new table live, comparators held in clear
module flagged_port_loader
    import flagged_port_loader_pkg::*;
#(
    parameter int NUM_PORTS    = 4,
    parameter int PORT_W       = 16,
    parameter int FLUSH_CYCLES = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    flagged_port_loader_if.slave        wr,
    input  logic                        frame_active_i,
    output logic [NUM_PORTS*PORT_W-1:0] flagged_port_o,
    output logic [NUM_PORTS-1:0]        port_valid_o,
    output logic                        comp_clear_o,
    output logic                        wr_err_o,
    output logic                        commit_done_o
);

    localparam int CNT_W = $clog2(FLUSH_CYCLES) + 1;
    localparam int TBL_W = NUM_PORTS * PORT_W;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [TBL_W-1:0]       shadow_port_q, shadow_port_d;
    logic [NUM_PORTS-1:0]   shadow_valid_q, shadow_valid_d;
    logic [TBL_W-1:0]       active_port_q, active_port_d;
    logic [NUM_PORTS-1:0]   active_valid_q, active_valid_d;
    logic                   clear_q, clear_d;
    logic                   err_q, err_d;
    logic                   done_q, done_d;

    opcode_e                op;
    logic [IDX_W-1:0]       idx;
    logic [PORT_W-1:0]      port_val;
    logic                   accept;

    assign op       = opcode_e'(wr.wr_data[OP_MSB:OP_LSB]);
    assign idx      = wr.wr_data[IDX_MSB:IDX_LSB];
    assign port_val = wr.wr_data[PORT_LSB +: PORT_W];

    // Ready is forced low during reset so the host cannot hand over a word
    // that the reset would silently discard.
    assign wr.wr_ready = (state_q == IDLE) && !rst;
    assign accept      = wr.wr_valid && wr.wr_ready;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        shadow_port_d  = shadow_port_q;
        shadow_valid_d = shadow_valid_q;
        active_port_d  = active_port_q;
        active_valid_d = active_valid_q;
        clear_d        = clear_q;
        err_d          = 1'b0;
        done_d         = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (op)
                        OP_WRITE: begin
                            if (idx >= IDX_W'(NUM_PORTS)) begin
                                err_d = 1'b1;
                            end else begin
                                for (int i = 0; i < NUM_PORTS; i++) begin
                                    if (idx == IDX_W'(i)) begin
                                        shadow_port_d[i*PORT_W +: PORT_W] = port_val;
                                        shadow_valid_d[i]                 = 1'b1;
                                    end
                                end
                            end
                        end
                        OP_CLEAR_ALL: shadow_valid_d = '0;
                        OP_COMMIT:    state_d        = WAIT_IDLE;
                        OP_NOP:       ;
                        default:      ;
                    endcase
                end
            end
            WAIT_IDLE: begin
                if (!frame_active_i) begin
                    active_port_d  = shadow_port_q;
                    active_valid_d = shadow_valid_q;
                    clear_d        = 1'b1;
                    cnt_d          = CNT_W'(FLUSH_CYCLES - 1);
                    state_d        = FLUSH;
                end
            end
            FLUSH: begin
                if (cnt_q == '0) begin
                    clear_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            shadow_port_q  <= '0;
            shadow_valid_q <= '0;
            active_port_q  <= '0;
            active_valid_q <= '0;
            clear_q        <= 1'b0;
            err_q          <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            shadow_port_q  <= shadow_port_d;
            shadow_valid_q <= shadow_valid_d;
            active_port_q  <= active_port_d;
            active_valid_q <= active_valid_d;
            clear_q        <= clear_d;
            err_q          <= err_d;
            done_q         <= done_d;
        end
    end

    assign flagged_port_o = active_port_q;
    assign port_valid_o   = active_valid_q;
    assign comp_clear_o   = clear_q;
    assign wr_err_o       = err_q;
    assign commit_done_o  = done_q;

endmodule

// File: tb/tb_flagged_port_loader.sv
// Directed bench for flagged_port_loader with hand-computed expected tables.
module tb_flagged_port_loader;
    import flagged_port_loader_pkg::*;

    localparam int NUM_PORTS    = 4;
    localparam int PORT_W       = 16;
    localparam int FLUSH_CYCLES = 3;

    logic                        clk;
    logic                        rst;
    logic                        frame_active;
    logic [NUM_PORTS*PORT_W-1:0] flagged_port;
    logic [NUM_PORTS-1:0]        port_valid;
    logic                        comp_clear;
    logic                        wr_err;
    logic                        commit_done;

    int n_checks;
    int n_errors;

    flagged_port_loader_if wr_if ();

    flagged_port_loader #(
        .NUM_PORTS    (NUM_PORTS),
        .PORT_W       (PORT_W),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .wr             (wr_if),
        .frame_active_i (frame_active),
        .flagged_port_o (flagged_port),
        .port_valid_o   (port_valid),
        .comp_clear_o   (comp_clear),
        .wr_err_o       (wr_err),
        .commit_done_o  (commit_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for ready, presents one word, returns 1ns after the accepting edge.
    task automatic issue(input logic [1:0] op, input int idx, input logic [15:0] port);
        int waited;
        waited = 0;
        while (!wr_if.wr_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!wr_if.wr_ready) begin
            check_eq("ready_timeout", 64'(wr_if.wr_ready), 64'd1);
        end else begin
            wr_if.wr_valid = 1'b1;
            wr_if.wr_data  = {op, 14'(idx), port};
            @(posedge clk); #1;
            wr_if.wr_valid = 1'b0;
            wr_if.wr_data  = '0;
        end
    endtask

    task automatic wait_done(input string tag);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (commit_done) begin
                got = 1'b1;
                break;
            end
        end
        check_eq(tag, 64'(got), 64'd1);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    logic [63:0] exp_tbl;
    int          clear_cnt;
    int          done_cnt;

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        rst            = 1'b1;
        frame_active   = 1'b0;
        wr_if.wr_valid = 1'b0;
        wr_if.wr_data  = '0;

        repeat (3) tick();
        check_eq("rst_ready_low", 64'(wr_if.wr_ready), 64'd0);
        check_eq("rst_table", flagged_port, 64'd0);
        check_eq("rst_valid", 64'(port_valid), 64'd0);
        check_eq("rst_clear", 64'(comp_clear), 64'd0);
        check_eq("rst_err", 64'(wr_err), 64'd0);
        check_eq("rst_done", 64'(commit_done), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("post_rst_ready", 64'(wr_if.wr_ready), 64'd1);

        // Basic commit: entries 0 and 2, clear held for FLUSH_CYCLES.
        issue(OP_WRITE, 0, 16'h0050);
        issue(OP_WRITE, 2, 16'h01BB);
        issue(OP_COMMIT, 0, 16'h0000);
        check_eq("wait_ready_low", 64'(wr_if.wr_ready), 64'd0);
        check_eq("pre_swap_valid", 64'(port_valid), 64'd0);
        tick();
        exp_tbl = 64'h0000_01BB_0000_0050;
        check_eq("c1_valid", 64'(port_valid), 64'h5);
        check_eq("c1_table", flagged_port, exp_tbl);
        check_eq("c1_clear_rise", 64'(comp_clear), 64'd1);
        clear_cnt = 1;
        done_cnt  = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (comp_clear) clear_cnt++;
            if (commit_done) begin
                done_cnt++;
                check_eq("c1_done_clear_low", 64'(comp_clear), 64'd0);
                check_eq("c1_done_ready", 64'(wr_if.wr_ready), 64'd1);
            end
        end
        check_eq("c1_clear_cycles", 64'(clear_cnt), 64'd3);
        check_eq("c1_done_pulses", 64'(done_cnt), 64'd1);

        // Shadow edit without commit must not reach the outputs.
        issue(OP_WRITE, 1, 16'h0016);
        for (int i = 0; i < 20; i++) begin
            tick();
            check_eq("nocommit_table", flagged_port, exp_tbl);
            check_eq("nocommit_valid", 64'(port_valid), 64'h5);
        end

        // Commit held off by an in-flight frame.
        frame_active = 1'b1;
        issue(OP_COMMIT, 0, 16'h0000);
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("busy_ready", 64'(wr_if.wr_ready), 64'd0);
            check_eq("busy_clear", 64'(comp_clear), 64'd0);
            check_eq("busy_table", flagged_port, exp_tbl);
            check_eq("busy_valid", 64'(port_valid), 64'h5);
        end
        frame_active = 1'b0;
        tick();
        exp_tbl = 64'h0000_01BB_0016_0050;
        check_eq("c2_table", flagged_port, exp_tbl);
        check_eq("c2_valid", 64'(port_valid), 64'h7);
        check_eq("c2_clear", 64'(comp_clear), 64'd1);
        wait_done("c2_done");

        // Out-of-range index: error pulse, table untouched.
        issue(OP_WRITE, 5, 16'hDEAD);
        check_eq("err_pulse", 64'(wr_err), 64'd1);
        tick();
        check_eq("err_pulse_end", 64'(wr_err), 64'd0);
        issue(OP_NOP, 0, 16'hBEEF);
        check_eq("nop_no_err", 64'(wr_err), 64'd0);
        issue(OP_COMMIT, 0, 16'h0000);
        tick();
        check_eq("c3_table", flagged_port, exp_tbl);
        check_eq("c3_valid", 64'(port_valid), 64'h7);
        wait_done("c3_done");

        // Same index twice: last write wins.
        issue(OP_WRITE, 3, 16'h1111);
        issue(OP_WRITE, 3, 16'h2222);
        issue(OP_COMMIT, 0, 16'h0000);
        tick();
        exp_tbl = 64'h2222_01BB_0016_0050;
        check_eq("c4_table", flagged_port, exp_tbl);
        check_eq("c4_valid", 64'(port_valid), 64'hF);
        wait_done("c4_done");

        // CLEAR_ALL drops enables but keeps values.
        issue(OP_CLEAR_ALL, 0, 16'h0000);
        check_eq("clr_no_err", 64'(wr_err), 64'd0);
        check_eq("clr_active_kept", 64'(port_valid), 64'hF);
        issue(OP_COMMIT, 0, 16'h0000);
        tick();
        check_eq("c5_valid", 64'(port_valid), 64'h0);
        check_eq("c5_table", flagged_port, exp_tbl);
        wait_done("c5_done");

        // Reset in the second flush cycle abandons the commit.
        issue(OP_WRITE, 0, 16'h0AAA);
        issue(OP_COMMIT, 0, 16'h0000);
        tick();
        check_eq("c6_flush1_clear", 64'(comp_clear), 64'd1);
        tick();
        check_eq("c6_flush2_clear", 64'(comp_clear), 64'd1);
        rst = 1'b1;
        #1;
        check_eq("arst_clear", 64'(comp_clear), 64'd0);
        check_eq("arst_table", flagged_port, 64'd0);
        check_eq("arst_valid", 64'(port_valid), 64'd0);
        check_eq("arst_done", 64'(commit_done), 64'd0);
        check_eq("arst_err", 64'(wr_err), 64'd0);
        check_eq("arst_ready", 64'(wr_if.wr_ready), 64'd0);
        tick();
        check_eq("arst_hold_ready", 64'(wr_if.wr_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("arst_release_ready", 64'(wr_if.wr_ready), 64'd1);
        issue(OP_COMMIT, 0, 16'h0000);
        tick();
        check_eq("c7_valid", 64'(port_valid), 64'h0);
        check_eq("c7_table", flagged_port, 64'd0);
        check_eq("c7_clear", 64'(comp_clear), 64'd1);
        wait_done("c7_done");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
